// File: rtl/mipi_csi_pkg.sv
// Shared constants for the CSI-2 transmit data path.
package mipi_csi_pkg;
    localparam logic [5:0] RAW10_DT           = 6'h2B;
    localparam int         RAW10_GROUP_BYTES  = 5;
    localparam int         RAW10_GROUP_PIXELS = 4;
    localparam int         LANE_BYTES         = 2;
    localparam int         PIXEL_W            = 10;
    localparam int         GROUP_W            = RAW10_GROUP_PIXELS * PIXEL_W;
    localparam int         BUF_BYTES          = 6;
    localparam logic [7:0] PAD_BYTE           = 8'h00;
endpackage

// File: rtl/mipi_csi_tx_raw10_packer_8b2lane_if.sv
// Pixel-group input and lane-word output bundle of the RAW10 packer.
// master = pixel source / word sink, slave = the packer itself.
interface mipi_csi_tx_raw10_packer_8b2lane_if;
    import mipi_csi_pkg::*;

    logic                              data_valid_i;
    logic [GROUP_W-1:0]                data_i;
    logic                              last_i;
    logic                              ready_o;
    logic [8*LANE_BYTES-1:0]           output_o;
    logic                              output_valid_o;
    logic                              output_last_o;

    modport master (
        output data_valid_i, data_i, last_i,
        input  ready_o, output_o, output_valid_o, output_last_o
    );

    modport slave (
        input  data_valid_i, data_i, last_i,
        output ready_o, output_o, output_valid_o, output_last_o
    );
endinterface

// File: rtl/mipi_csi_tx_raw10_group_pack.sv
// Reorders four 10-bit pixels into the five RAW10 stream bytes {B4..B0}.
module mipi_csi_tx_raw10_group_pack
    import mipi_csi_pkg::*;
(
    input  logic [GROUP_W-1:0] group_i,
    output logic [GROUP_W-1:0] bytes_o
);

    // B0..B3 are the pixel MSBs; B4 collects the two LSBs of every pixel.
    always_comb begin
        bytes_o = '0;
        for (int p = 0; p < RAW10_GROUP_PIXELS; p++) begin
            bytes_o[8*p +: 8]      = group_i[PIXEL_W*p + 2 +: 8];
            bytes_o[32 + 2*p +: 2] = group_i[PIXEL_W*p +: 2];
        end
    end

endmodule

// File: rtl/mipi_csi_tx_raw10_packer_8b2lane.sv
// RAW10 transmit packer: buffers stream bytes and emits two lane bytes per clock,
// padding the final word of a line when it ends on an odd byte.
module mipi_csi_tx_raw10_packer_8b2lane
    import mipi_csi_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    mipi_csi_tx_raw10_packer_8b2lane_if.slave bus
);

    logic [8*BUF_BYTES-1:0]  buf_q, buf_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    lep_q, lep_d;
    logic [15:0]             out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;

    logic [GROUP_W-1:0]      group_bytes;
    logic                    transfer;
    logic [63:0]             stream;
    logic [3:0]              total;
    logic                    lep_next;

    mipi_csi_tx_raw10_group_pack u_group_pack (
        .group_i (bus.data_i),
        .bytes_o (group_bytes)
    );

    // A group is only accepted when all five bytes fit and no line is draining.
    assign bus.ready_o = !reset_i && (cnt_q <= 3'd3) && !lep_q;
    assign transfer    = bus.data_valid_i && bus.ready_o;

    assign bus.output_o       = out_q;
    assign bus.output_valid_o = out_valid_q;
    assign bus.output_last_o  = out_last_q;

    // Append the new group behind the buffered bytes and peel off the oldest two.
    // Bytes above the occupancy are kept at zero so the OR-merge stays clean.
    always_comb begin
        stream   = {16'b0, buf_q};
        total    = {1'b0, cnt_q};
        lep_next = lep_q;
        if (transfer) begin
            stream   = stream | ({24'b0, group_bytes} << {cnt_q, 3'b000});
            total    = total + 4'(RAW10_GROUP_BYTES);
            lep_next = lep_q | bus.last_i;
        end

        buf_d       = stream[47:0];
        cnt_d       = total[2:0];
        lep_d       = lep_next;
        out_d       = out_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;

        if (total >= 4'd2) begin
            out_d       = stream[15:0];
            out_valid_d = 1'b1;
            buf_d       = stream[63:16];
            cnt_d       = 3'(total - 4'd2);
            if (lep_next && total == 4'd2) begin
                out_last_d = 1'b1;
                lep_d      = 1'b0;
            end
        end else if (total == 4'd1 && lep_next) begin
            out_d       = {PAD_BYTE, stream[7:0]};
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            buf_d       = '0;
            cnt_d       = 3'd0;
            lep_d       = 1'b0;
        end
    end

    // State and registered outputs; reset drops any partially buffered line.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buf_q       <= '0;
            cnt_q       <= 3'd0;
            lep_q       <= 1'b0;
            out_q       <= 16'h0000;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            lep_q       <= lep_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_mipi_csi_tx_raw10_packer_8b2lane.sv
// Directed bench for the RAW10 2-lane packer.
module tb_mipi_csi_tx_raw10_packer_8b2lane;
    import mipi_csi_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i;

    mipi_csi_tx_raw10_packer_8b2lane_if bus();

    mipi_csi_tx_raw10_packer_8b2lane dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    logic [15:0] wq[$];
    logic        lq[$];
    int          sq[$];
    logic        rq[$];
    logic [15:0] ew[$];
    logic        el[$];
    logic [7:0]  bq[$];
    logic [39:0] gd;
    logic [7:0]  b4;
    logic [7:0]  hi;
    logic [1:0]  lo;
    logic [15:0] lsb_word[3];
    logic [39:0] lsb_grp[3];
    bit          exp_rdy[10] = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 1};

    // Collect every valid output word with the cycle it appeared in.
    always @(posedge clk_i) begin
        cyc++;
        #1;
        if (bus.output_valid_o === 1'b1) begin
            wq.push_back(bus.output_o);
            lq.push_back(bus.output_last_o);
            sq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] grp(input logic [9:0] p0, input logic [9:0] p1,
                                        input logic [9:0] p2, input logic [9:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic clear_q();
        wq.delete(); lq.delete(); sq.delete(); rq.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [39:0] d, input logic l);
        int n;
        n = 0;
        bus.data_valid_i = 1'b1;
        bus.data_i       = d;
        bus.last_i       = l;
        rq.push_back(bus.ready_o);
        while (bus.ready_o !== 1'b1 && n < 40) begin
            @(negedge clk_i);
            n++;
            rq.push_back(bus.ready_o);
        end
        if (n >= 40) check("send_timeout", 32'(n), 32'd0);
        @(negedge clk_i);
        acc_cyc = cyc;
    endtask

    task automatic idle();
        bus.data_valid_i = 1'b0;
        bus.last_i       = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int k;
        k = 0;
        while (wq.size() < n && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        repeat (5) @(negedge clk_i);
        check({tag, "_count"}, 32'(wq.size()), 32'(n));
    endtask

    task automatic expect_words(input string tag);
        for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), 32'(wq[i]), 32'(ew[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(lq[i]), 32'(el[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_i          = 1'b1;
        bus.data_valid_i = 1'b0;
        bus.data_i       = '0;
        bus.last_i       = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_out", 32'(bus.output_o), 32'd0);
        check("rst_valid", 32'(bus.output_valid_o), 32'd0);
        check("rst_last", 32'(bus.output_last_o), 32'd0);
        reset_i = 1'b0;
        #1;
        check("rel_ready", 32'(bus.ready_o), 32'd1);
        @(negedge clk_i);

        // Two-group line.
        clear_q();
        send(grp(10'h004, 10'h008, 10'h00C, 10'h010), 1'b0);
        send(grp(10'h014, 10'h018, 10'h01C, 10'h020), 1'b1);
        idle();
        wait_words("two_grp", 5);
        ew = '{16'h0201, 16'h0403, 16'h0500, 16'h0706, 16'h0008};
        el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        expect_words("two_grp");
        check("two_grp_gapless", 32'(sq[4] - sq[0]), 32'd4);

        // Odd-length line: single group, padded last word.
        clear_q();
        send(grp(10'h004, 10'h008, 10'h00C, 10'h010), 1'b1);
        idle();
        check("odd_latency", 32'(sq.size() > 0 ? sq[0] : -1), 32'(acc_cyc));
        wait_words("odd", 3);
        ew = '{16'h0201, 16'h0403, 16'h0000};
        el = '{1'b0, 1'b0, 1'b1};
        expect_words("odd");

        // LSB packing into B4.
        lsb_grp[0] = grp(10'h007, 10'h008, 10'h00C, 10'h010); lsb_word[0] = 16'h0003;
        lsb_grp[1] = grp(10'h004, 10'h008, 10'h00F, 10'h010); lsb_word[1] = 16'h0030;
        lsb_grp[2] = grp(10'h004, 10'h008, 10'h00C, 10'h013); lsb_word[2] = 16'h00C0;
        for (int i = 0; i < 3; i++) begin
            clear_q();
            send(lsb_grp[i], 1'b1);
            idle();
            wait_words($sformatf("lsb%0d", i), 3);
            ew = '{16'h0201, 16'h0403, lsb_word[i]};
            el = '{1'b0, 1'b0, 1'b1};
            expect_words($sformatf("lsb%0d", i));
        end

        // Continuous valid, 8 groups, last on the 8th.
        clear_q();
        bq.delete();
        for (int g = 0; g < 8; g++) begin
            gd = '0;
            b4 = '0;
            for (int k = 0; k < 4; k++) begin
                hi = 8'(16 * g + k + 1);
                lo = 2'((g + k) % 4);
                gd[10*k +: 10] = {hi, lo};
                b4[2*k +: 2]   = lo;
                bq.push_back(hi);
            end
            bq.push_back(b4);
            send(gd, g == 7);
        end
        idle();
        wait_words("cont", 20);
        ew.delete();
        el.delete();
        for (int i = 0; i < 20; i++) begin
            ew.push_back({bq[2*i+1], bq[2*i]});
            el.push_back(i == 19);
        end
        expect_words("cont");
        if (sq.size() == 20) check("cont_gapless", 32'(sq[19] - sq[0]), 32'd19);
        for (int i = 0; i < 10 && i < rq.size(); i++)
            check($sformatf("cont_ready%0d", i), 32'(rq[i]), 32'(exp_rdy[i]));

        // Back-to-back lines with valid held across the boundary.
        clear_q();
        send(grp(10'h004, 10'h008, 10'h00C, 10'h010), 1'b1);
        rq.delete();
        send(grp(10'h014, 10'h018, 10'h01C, 10'h020), 1'b1);
        idle();
        check("b2b_ready_wait", 32'(rq.size()), 32'd3);
        for (int i = 0; i < 3 && i < rq.size(); i++)
            check($sformatf("b2b_ready%0d", i), 32'(rq[i]), 32'(i == 2));
        wait_words("b2b", 6);
        ew = '{16'h0201, 16'h0403, 16'h0000, 16'h0605, 16'h0807, 16'h0000};
        el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        expect_words("b2b");
        if (sq.size() == 6) begin
            check("b2b_next_line_gap", 32'(sq[3] - sq[2]), 32'd1);
            check("b2b_next_latency", 32'(sq[3]), 32'(acc_cyc));
        end

        // Reset mid-line with four bytes buffered.
        clear_q();
        send(grp(10'h004, 10'h008, 10'h00C, 10'h010), 1'b0);
        send(grp(10'h014, 10'h018, 10'h01C, 10'h020), 1'b1);
        idle();
        @(negedge clk_i);
        check("pre_rst_word", 32'(bus.output_o), 32'h0500);
        check("pre_rst_valid", 32'(bus.output_valid_o), 32'd1);
        reset_i = 1'b1;
        #1;
        check("midrst_out", 32'(bus.output_o), 32'd0);
        check("midrst_valid", 32'(bus.output_valid_o), 32'd0);
        check("midrst_last", 32'(bus.output_last_o), 32'd0);
        check("midrst_ready", 32'(bus.ready_o), 32'd0);
        clear_q();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("post_rst_no_words", 32'(wq.size()), 32'd0);
        send(grp(10'h004, 10'h008, 10'h00C, 10'h010), 1'b1);
        idle();
        wait_words("post_rst", 3);
        ew = '{16'h0201, 16'h0403, 16'h0000};
        el = '{1'b0, 1'b0, 1'b1};
        expect_words("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
